// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-line instruction cache with flush and performance counters
//
// Parameters:
//   INDEX_WIDTH  log2 of the number of one-word lines
// Ports:
//   clk_in, rst_in            clock, synchronous active-low reset
//   rdy_in                    global enable; low holds every register
//   flush                     misprediction flush
//   fe_en, fe_addr            fetch request from the decoder
//   fe_rdy, fe_data           one-cycle response pulse and instruction word
//   mem_en, mem_addr          word read request towards the memory controller
//   mem_rdy, mem_data         memory read response
//   hit_cnt, miss_cnt         wrapping performance counters

module icache #(
    parameter int INDEX_WIDTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        fe_en,
    input  logic [31:0] fe_addr,
    output logic        fe_rdy,
    output logic [31:0] fe_data,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [31:0] mem_data,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 30 - INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MISS    = 2'd1,
        RESPOND = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t state;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [INDEX_WIDTH-1:0] fe_idx;
    logic [TAG_W-1:0]       fe_tag;
    logic [INDEX_WIDTH-1:0] fill_idx;
    logic [TAG_W-1:0]       fill_tag;
    logic                   hit;

    // Byte offset of the fetch address has no meaning for a word cache.
    logic unused_offset;
    assign unused_offset = &{1'b0, fe_addr[1:0]};

    assign fe_idx = fe_addr[INDEX_WIDTH+1:2];
    assign fe_tag = fe_addr[31:INDEX_WIDTH+2];

    // A fill always targets the latched request address, not the live
    // fetch address, because the decoder may move on after a flush.
    assign fill_idx = mem_addr[INDEX_WIDTH+1:2];
    assign fill_tag = mem_addr[31:INDEX_WIDTH+2];

    assign hit = valid[fe_idx] && (tag_mem[fe_idx] == fe_tag);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            valid    <= '0;
            fe_rdy   <= 1'b0;
            fe_data  <= '0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    fe_rdy <= 1'b0;
                    // A flush in the same cycle as a request drops it entirely.
                    if (fe_en && !flush) begin
                        if (hit) begin
                            fe_data <= data_mem[fe_idx];
                            hit_cnt <= hit_cnt + 32'd1;
                            fe_rdy  <= 1'b1;
                            state   <= RESPOND;
                        end else begin
                            mem_addr <= {fe_addr[31:2], 2'b00};
                            miss_cnt <= miss_cnt + 32'd1;
                            mem_en   <= 1'b1;
                            state    <= MISS;
                        end
                    end
                end

                MISS: begin
                    if (mem_rdy) begin
                        valid[fill_idx]    <= 1'b1;
                        tag_mem[fill_idx]  <= fill_tag;
                        data_mem[fill_idx] <= mem_data;
                        mem_en             <= 1'b0;
                        if (flush) begin
                            // Line is still worth keeping, only the response is dropped.
                            state <= IDLE;
                        end else begin
                            fe_data <= mem_data;
                            fe_rdy  <= 1'b1;
                            state   <= RESPOND;
                        end
                    end else if (flush) begin
                        // The memory controller cannot cancel a read, so wait it out.
                        state <= DRAIN;
                    end
                end

                RESPOND: begin
                    fe_rdy <= 1'b0;
                    state  <= IDLE;
                end

                DRAIN: begin
                    if (mem_rdy) begin
                        valid[fill_idx]    <= 1'b1;
                        tag_mem[fill_idx]  <= fill_tag;
                        data_mem[fill_idx] <= mem_data;
                        mem_en             <= 1'b0;
                        state              <= IDLE;
                    end
                end

                default: begin
                    fe_rdy <= 1'b0;
                    mem_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache

module tb_icache;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        fe_en;
    logic [31:0] fe_addr;
    logic        fe_rdy;
    logic [31:0] fe_data;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic        mem_rdy;
    logic [31:0] mem_data;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int total;
    int bad;

    logic [31:0] exp_q[$];

    icache #(.INDEX_WIDTH(4)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush    (flush),
        .fe_en    (fe_en),
        .fe_addr  (fe_addr),
        .fe_rdy   (fe_rdy),
        .fe_data  (fe_data),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_rdy  (mem_rdy),
        .mem_data (mem_data),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Scoreboard: every fe_rdy pulse must match the oldest expected word.
    always @(negedge clk_in) begin
        if (rst_in && fe_rdy) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL sb_unexpected_rdy: got fe_data=%h, required no response", fe_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (fe_data !== e) begin
                    bad = bad + 1;
                    $display("FAIL sb_fe_data: got %h, required %h", fe_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    // Drive one complete fetch; the memory answers mem_delay cycles after
    // the miss is seen. Reports whether it missed and edges to fe_rdy.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word,
                         input int mem_delay, output bit was_miss,
                         output bit seen, output int lat);
        fe_addr = addr;
        fe_en   = 1'b1;
        exp_q.push_back(word);
        tick();
        was_miss = mem_en;
        if (mem_en) begin
            repeat (mem_delay) tick();
            mem_data = word;
            mem_rdy  = 1'b1;
            tick();
            mem_rdy  = 1'b0;
        end
        lat = 1;
        while (!fe_rdy && lat < 20) begin
            tick();
            lat++;
        end
        seen  = fe_rdy;
        fe_en = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        rdy_in = 1'b0;
        tick();
        tick();
        total++; if (fe_rdy !== 1'b0)    begin bad++; $display("FAIL reset_fe_rdy: got %b, required 0", fe_rdy); end
        total++; if (fe_data !== 32'h0)  begin bad++; $display("FAIL reset_fe_data: got %h, required 0", fe_data); end
        total++; if (mem_en !== 1'b0)    begin bad++; $display("FAIL reset_mem_en: got %b, required 0", mem_en); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
        total++; if (hit_cnt !== 32'h0)  begin bad++; $display("FAIL reset_hit_cnt: got %0d, required 0", hit_cnt); end
        total++; if (miss_cnt !== 32'h0) begin bad++; $display("FAIL reset_miss_cnt: got %0d, required 0", miss_cnt); end
        rst_in = 1'b1;
        rdy_in = 1'b1;
        tick();
    endtask

    task automatic test_cold_miss;
        fe_addr = 32'h0000_0000;
        fe_en   = 1'b1;
        exp_q.push_back(32'h0000_0513);
        tick();
        total++; if (mem_en !== 1'b1)     begin bad++; $display("FAIL cold_mem_en: got %b, required 1", mem_en); end
        total++; if (mem_addr !== 32'h0)  begin bad++; $display("FAIL cold_mem_addr: got %h, required 0", mem_addr); end
        total++; if (miss_cnt !== 32'd1)  begin bad++; $display("FAIL cold_miss_cnt: got %0d, required 1", miss_cnt); end
        tick();
        tick();
        total++; if (fe_rdy !== 1'b0 || mem_en !== 1'b1) begin bad++; $display("FAIL cold_wait: got fe_rdy=%b mem_en=%b, required 0/1", fe_rdy, mem_en); end
        mem_data = 32'h0000_0513;
        mem_rdy  = 1'b1;
        tick();
        mem_rdy  = 1'b0;
        total++; if (fe_rdy !== 1'b1)     begin bad++; $display("FAIL cold_latency: got fe_rdy=%b, required 1 one cycle after mem_rdy", fe_rdy); end
        fe_en = 1'b0;
        tick();
        total++; if (fe_rdy !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL cold_end: got fe_rdy=%b mem_en=%b, required 0/0", fe_rdy, mem_en); end
    endtask

    task automatic test_hit;
        fe_addr = 32'h0000_0000;
        fe_en   = 1'b1;
        exp_q.push_back(32'h0000_0513);
        tick();
        total++; if (mem_en !== 1'b0)    begin bad++; $display("FAIL hit_mem_en: got %b, required 0", mem_en); end
        total++; if (fe_rdy !== 1'b1)    begin bad++; $display("FAIL hit_latency: got fe_rdy=%b, required 1 in the cycle after request", fe_rdy); end
        total++; if (hit_cnt !== 32'd1)  begin bad++; $display("FAIL hit_cnt: got %0d, required 1", hit_cnt); end
        fe_en = 1'b0;
        tick();
        total++; if (fe_rdy !== 1'b0)    begin bad++; $display("FAIL hit_pulse: got fe_rdy=%b, required 0", fe_rdy); end
    endtask

    task automatic test_conflict;
        bit m;
        bit s;
        int l;
        fetch(32'h0000_0040, 32'hAAAA_0040, 1, m, s, l);
        total++; if (m !== 1'b1 || s !== 1'b1) begin bad++; $display("FAIL conflict_first: got miss=%b seen=%b, required 1/1", m, s); end
        fetch(32'h0000_0000, 32'h0000_0513, 0, m, s, l);
        total++; if (m !== 1'b1 || s !== 1'b1) begin bad++; $display("FAIL conflict_evicted: got miss=%b seen=%b, required 1/1", m, s); end
        total++; if (miss_cnt !== 32'd3) begin bad++; $display("FAIL conflict_miss_cnt: got %0d, required 3", miss_cnt); end
        total++; if (hit_cnt !== 32'd1)  begin bad++; $display("FAIL conflict_hit_cnt: got %0d, required 1", hit_cnt); end
    endtask

    task automatic test_flush_miss;
        bit m;
        bit s;
        int l;
        fe_addr = 32'h0000_0010;
        fe_en   = 1'b1;
        tick();
        total++; if (mem_en !== 1'b1 || mem_addr !== 32'h10) begin bad++; $display("FAIL fmiss_req: got mem_en=%b mem_addr=%h, required 1/00000010", mem_en, mem_addr); end
        flush = 1'b1;
        fe_en = 1'b0;
        tick();
        flush = 1'b0;
        total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL fmiss_drain1: got mem_en=%b, required 1", mem_en); end
        tick();
        total++; if (mem_en !== 1'b1 || mem_addr !== 32'h10) begin bad++; $display("FAIL fmiss_drain2: got mem_en=%b mem_addr=%h, required 1/00000010", mem_en, mem_addr); end
        mem_data = 32'h1234_5678;
        mem_rdy  = 1'b1;
        tick();
        mem_rdy  = 1'b0;
        total++; if (mem_en !== 1'b0 || fe_rdy !== 1'b0) begin bad++; $display("FAIL fmiss_done: got mem_en=%b fe_rdy=%b, required 0/0", mem_en, fe_rdy); end
        tick();
        total++; if (fe_rdy !== 1'b0) begin bad++; $display("FAIL fmiss_no_rdy: got %b, required 0", fe_rdy); end
        fetch(32'h0000_0010, 32'h1234_5678, 0, m, s, l);
        total++; if (m !== 1'b0 || s !== 1'b1 || l != 1) begin bad++; $display("FAIL fmiss_refetch: got miss=%b seen=%b lat=%0d, required 0/1/1", m, s, l); end
        total++; if (miss_cnt !== 32'd4 || hit_cnt !== 32'd2) begin bad++; $display("FAIL fmiss_cnts: got miss=%0d hit=%0d, required 4/2", miss_cnt, hit_cnt); end
    endtask

    task automatic test_flush_same_cycle;
        bit m;
        bit s;
        int l;
        fe_addr = 32'h0000_0014;
        fe_en   = 1'b1;
        tick();
        flush    = 1'b1;
        fe_en    = 1'b0;
        mem_data = 32'hCAFE_0014;
        mem_rdy  = 1'b1;
        tick();
        flush    = 1'b0;
        mem_rdy  = 1'b0;
        total++; if (mem_en !== 1'b0 || fe_rdy !== 1'b0) begin bad++; $display("FAIL fsame_idle: got mem_en=%b fe_rdy=%b, required 0/0", mem_en, fe_rdy); end
        fetch(32'h0000_0014, 32'hCAFE_0014, 0, m, s, l);
        total++; if (m !== 1'b0 || s !== 1'b1) begin bad++; $display("FAIL fsame_filled: got miss=%b seen=%b, required 0/1", m, s); end
    endtask

    task automatic test_flush_idle;
        fe_addr = 32'h0000_0020;
        fe_en   = 1'b1;
        flush   = 1'b1;
        tick();
        total++; if (mem_en !== 1'b0 || miss_cnt !== 32'd5) begin bad++; $display("FAIL fidle_miss: got mem_en=%b miss=%0d, required 0/5", mem_en, miss_cnt); end
        fe_addr = 32'h0000_0000;
        tick();
        total++; if (fe_rdy !== 1'b0 || hit_cnt !== 32'd3) begin bad++; $display("FAIL fidle_hit: got fe_rdy=%b hit=%0d, required 0/3", fe_rdy, hit_cnt); end
        flush = 1'b0;
        fe_en = 1'b0;
        tick();
    endtask

    task automatic test_rdy_hold;
        fe_addr = 32'h0000_0024;
        fe_en   = 1'b1;
        exp_q.push_back(32'h2424_2424);
        tick();
        rdy_in = 1'b0;
        flush  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (mem_en !== 1'b1 || mem_addr !== 32'h24 || fe_rdy !== 1'b0 || miss_cnt !== 32'd6) begin
                bad++;
                $display("FAIL hold_%0d: got mem_en=%b mem_addr=%h fe_rdy=%b miss=%0d, required 1/00000024/0/6", i, mem_en, mem_addr, fe_rdy, miss_cnt);
            end
        end
        flush  = 1'b0;
        rdy_in = 1'b1;
        tick();
        total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL hold_resume: got mem_en=%b, required 1", mem_en); end
        mem_data = 32'h2424_2424;
        mem_rdy  = 1'b1;
        tick();
        mem_rdy  = 1'b0;
        total++; if (fe_rdy !== 1'b1) begin bad++; $display("FAIL hold_complete: got fe_rdy=%b, required 1", fe_rdy); end
        fe_en = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [16];
        bit m;
        bit s;
        int l;
        int misses;
        int hits;
        misses = 0;
        hits   = 0;
        for (int i = 0; i < 16; i++) begin
            words[i] = $urandom();
            fetch(32'h0000_1000 + 32'(i * 4), words[i], i % 3, m, s, l);
            if (m) misses++;
        end
        for (int i = 0; i < 16; i++) begin
            fetch(32'h0000_1000 + 32'(i * 4), words[i], 0, m, s, l);
            if (!m && s) hits++;
        end
        total++; if (misses != 16) begin bad++; $display("FAIL b2b_fill: got %0d misses, required 16", misses); end
        total++; if (hits != 16)   begin bad++; $display("FAIL b2b_hits: got %0d hits, required 16", hits); end
    endtask

    task automatic test_reset_mid_miss;
        bit m;
        bit s;
        int l;
        fe_addr = 32'h0000_1008;
        fe_en   = 1'b1;
        tick();
        rst_in = 1'b0;
        fe_en  = 1'b0;
        tick();
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rmid_mem_en: got %b, required 0", mem_en); end
        total++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin bad++; $display("FAIL rmid_cnts: got hit=%0d miss=%0d, required 0/0", hit_cnt, miss_cnt); end
        rst_in = 1'b1;
        tick();
        fetch(32'h0000_1000, 32'h0BAD_F00D, 0, m, s, l);
        total++; if (m !== 1'b1 || s !== 1'b1) begin bad++; $display("FAIL rmid_cold: got miss=%b seen=%b, required 1/1", m, s); end
        total++; if (miss_cnt !== 32'd1) begin bad++; $display("FAIL rmid_miss_cnt: got %0d, required 1", miss_cnt); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        flush    = 1'b0;
        fe_en    = 1'b0;
        fe_addr  = '0;
        mem_rdy  = 1'b0;
        mem_data = '0;

        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_miss();
        test_flush_same_cycle();
        test_flush_idle();
        test_rdy_hold();
        test_back_to_back();
        test_reset_mid_miss();

        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending responses, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
